cdb_arbiter: RTL

Producer-side driver of the common data bus (CDB). Collects completed results (data plus ROB tag) from the functional units, buffers each in a small per-source FIFO, and broadcasts at most one result per cycle onto the registered `CDB` bus (`valid`, `data[15:0]`, `tag[2:0]`) consumed by the reservation stations, register file and ROB. Arbitration is round-robin. A flush input discards all pending results on misprediction.

---
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers completed results from each functional unit in a small
// per-source FIFO and broadcasts at most one per cycle on the registered CDB,
// choosing among non-empty FIFOs in round-robin order. Flush drops everything.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC-1:0][15:0] src_data,
    input  logic [NUM_SRC-1:0][2:0]  src_tag,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic [19:0]              cdb_out,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(NUM_SRC);

    localparam logic [CW-1:0] FullCount = CW'(DEPTH);
    localparam logic [SW-1:0] LastSrc   = SW'(NUM_SRC - 1);

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  tag;
    } entry_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
        logic [2:0]  tag;
    } cdb_t;

    // FIFO storage and bookkeeping, one set per source
    entry_t        mem_q   [NUM_SRC][DEPTH];
    logic [CW-1:0] count_q [NUM_SRC];
    logic [CW-1:0] count_d [NUM_SRC];
    logic [AW-1:0] head_q  [NUM_SRC];
    logic [AW-1:0] head_d  [NUM_SRC];
    logic [AW-1:0] tail_q  [NUM_SRC];
    logic [AW-1:0] tail_d  [NUM_SRC];

    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    cdb_t          cdb_q, cdb_d;

    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_valid;
    logic [SW-1:0]      grant_idx;
    int unsigned        cand;
    logic [SW-1:0]      cand_idx;

    // Status flags come only from registered counts, never from this cycle's pop
    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            nonempty[i]  = (count_q[i] != '0);
            src_ready[i] = (count_q[i] != FullCount);
            busy         = busy | nonempty[i];
        end
    end

    // Round-robin search from rr_ptr upward over FIFOs non-empty at cycle start
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = SW'(cand);
            if (!grant_valid && nonempty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Next-state: pushes, grant pop, CDB word and pointer updates; flush clears all
    always_comb begin
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        rr_ptr_d = rr_ptr_q;
        cdb_d    = '0;
        push     = '0;
        pop      = '0;

        if (flush) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                count_d[i] = '0;
                head_d[i]  = '0;
                tail_d[i]  = '0;
            end
            rr_ptr_d = '0;
        end else begin
            push = src_valid & src_ready;

            if (grant_valid) begin
                pop[grant_idx] = 1'b1;
                cdb_d.valid    = 1'b1;
                cdb_d.data     = mem_q[grant_idx][head_q[grant_idx]].data;
                cdb_d.tag      = mem_q[grant_idx][head_q[grant_idx]].tag;
                rr_ptr_d       = (grant_idx == LastSrc) ? '0 : grant_idx + SW'(1);
            end

            // DEPTH is a power of two, so the pointers wrap naturally
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (push[i]) begin
                    tail_d[i] = tail_q[i] + AW'(1);
                end
                if (pop[i]) begin
                    head_d[i] = head_q[i] + AW'(1);
                end
                count_d[i] = count_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    // Entry storage: written at the tail on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem_q[i][tail_q[i]] <= {src_data[i], src_tag[i]};
            end
        end
    end

    // Control state and the registered CDB word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                count_q[i] <= '0;
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
            end
            rr_ptr_q <= '0;
            cdb_q    <= '0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign cdb_out = cdb_q;

endmodule
